// File: rtl/byte_serial_bus_bridge_if.sv
// byte_serial_bus_bridge_if: CPU request and pad bus bundle for the bridge; PAD_WAIT_EN adds pad_wait
interface byte_serial_bus_bridge_if #(
  parameter int DATA_W = 32,
  parameter int BUS_W = 8,
  parameter int ADDR_W = 32
);
  logic [BUS_W-1:0] pad_in, pad_out;
  logic pad_strobe;
  logic [1:0] pad_phase;
  logic [ADDR_W-1:0] fetch_addr, req_addr;
  logic req_valid, req_we, req_re, req_ready;
  logic [DATA_W-1:0] req_wdata, instr, rdata;
  logic rdata_valid, cpu_step, busy;
`ifdef PAD_WAIT_EN
  logic pad_wait;
`endif
  modport slave(
    input pad_in, fetch_addr, req_valid, req_we, req_re, req_addr, req_wdata,
`ifdef PAD_WAIT_EN
    input pad_wait,
`endif
    output pad_out, pad_strobe, pad_phase, req_ready, instr, rdata, rdata_valid, cpu_step, busy
  );
  modport master(
    output pad_in, fetch_addr, req_valid, req_we, req_re, req_addr, req_wdata,
`ifdef PAD_WAIT_EN
    output pad_wait,
`endif
    input pad_out, pad_strobe, pad_phase, req_ready, instr, rdata, rdata_valid, cpu_step, busy
  );
endinterface

// File: rtl/byte_serial_bus_bridge.sv
// byte_serial_bus_bridge: beat-serial fetch/load/store bridge onto a narrow pad bus; PAD_WAIT_EN adds pad_wait stalls
module byte_serial_bus_bridge #(
  parameter int DATA_W = 32,
  parameter int BUS_W = 8,
  parameter int ADDR_W = 32,
  parameter int TURN_CYC = 1
) (
  input logic clk,
  input logic rst,
  byte_serial_bus_bridge_if.slave b
);
  localparam int AB = ADDR_W / BUS_W;
  localparam int DB = DATA_W / BUS_W;
  localparam int MX0 = AB > DB ? AB : DB;
  localparam int MX = MX0 > TURN_CYC ? MX0 : TURN_CYC;
  localparam int CW = MX > 1 ? $clog2(MX) : 1;
  localparam logic [CW-1:0] AL = CW'(AB - 1);
  localparam logic [CW-1:0] DL = CW'(DB - 1);
  localparam logic [CW-1:0] TL = CW'(TURN_CYC > 0 ? TURN_CYC - 1 : 0);
  typedef enum logic [3:0] {IDLE, FETCH_A, TURN, FETCH_D, STEP, MEM_A, MEM_WD, MEM_RD, RESP} state_t;
  state_t state, nxt, rd_st, turn_st;
  logic [CW-1:0] cnt, nc;
  logic [AB-1:0][BUS_W-1:0] fa, fa_n, ad, ad_n;
  logic [DB-1:0][BUS_W-1:0] wd, instr, rdata;
  logic l_we, l_re, act, stall, last;
  assign b.instr = instr;
  assign b.rdata = rdata;
`ifdef PAD_WAIT_EN
  assign stall = b.pad_wait && state inside {FETCH_A, FETCH_D, MEM_A, MEM_WD, MEM_RD};
`else
  assign stall = 1'b0;
`endif
  // next state and beat index; act marks a latched CPU request so the shared TURN knows which read follows
  always_comb begin
    rd_st = act ? MEM_RD : FETCH_D;
    turn_st = TURN_CYC == 0 ? rd_st : TURN;
    last = cnt == (state inside {FETCH_A, MEM_A} ? AL : state == TURN ? TL : DL);
    nxt = state;
    if (!stall)
      case (state)
        IDLE: nxt = FETCH_A;
        FETCH_A: nxt = last ? turn_st : FETCH_A;
        TURN: nxt = last ? rd_st : TURN;
        FETCH_D: nxt = last ? STEP : FETCH_D;
        STEP: nxt = b.req_valid && (b.req_we || b.req_re) ? MEM_A : FETCH_A;
        MEM_A: nxt = last ? (l_we ? MEM_WD : turn_st) : MEM_A;
        MEM_WD: nxt = last ? (l_re ? turn_st : FETCH_A) : MEM_WD;
        MEM_RD: nxt = last ? RESP : MEM_RD;
        RESP: nxt = FETCH_A;
        default: nxt = IDLE;
      endcase
    nc = nxt != state ? '0 : stall ? cnt : cnt + 1'b1;
    fa_n = nxt == FETCH_A && state != FETCH_A ? b.fetch_addr : fa;
    ad_n = state == STEP && nxt == MEM_A ? b.req_addr : ad;
  end
  // state, latches, read-beat capture and outputs registered from the state being entered
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      fa <= '0;
      ad <= '0;
      wd <= '0;
      l_we <= 1'b0;
      l_re <= 1'b0;
      act <= 1'b0;
      instr <= '0;
      rdata <= '0;
      b.pad_out <= '0;
      b.pad_strobe <= 1'b0;
      b.pad_phase <= 2'd0;
      b.req_ready <= 1'b0;
      b.rdata_valid <= 1'b0;
      b.cpu_step <= 1'b0;
      b.busy <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= nc;
      fa <= fa_n;
      ad <= ad_n;
      if (state == STEP && nxt == MEM_A) begin
        wd <= b.req_wdata;
        l_we <= b.req_we;
        l_re <= b.req_re;
      end
      act <= nxt != FETCH_A && (act || nxt == MEM_A);
      if (state == FETCH_D && !stall) instr[cnt] <= b.pad_in;
      if (state == MEM_RD && !stall) rdata[cnt] <= b.pad_in;
      b.pad_out <= nxt == FETCH_A ? fa_n[nc] : nxt == MEM_A ? ad_n[nc] : nxt == MEM_WD ? wd[nc] : '0;
      b.pad_strobe <= nxt inside {FETCH_A, MEM_A, MEM_WD};
      b.pad_phase <= nxt inside {FETCH_A, MEM_A} ? 2'd1 : nxt == MEM_WD ? 2'd2 : nxt inside {FETCH_D, MEM_RD} ? 2'd3 : 2'd0;
      b.req_ready <= nxt == STEP;
      b.rdata_valid <= nxt == RESP;
      b.cpu_step <= nxt inside {STEP, RESP};
      b.busy <= !(nxt inside {STEP, RESP});
    end
endmodule
